// File: rtl/mod12_counter_pkg.sv
// Shared constants for the modulo counter: default sequence length, width and reset value.
package mod12_counter_pkg;

  localparam int DEF_MODULUS = 12;
  localparam int DEF_WIDTH   = 4;
  localparam int RESET_VALUE = 0;

endpackage : mod12_counter_pkg

// File: rtl/mod12_counter.sv
// Modulo-MODULUS up-counter with synchronous parallel load; out-of-range loads
// are rejected to zero and flagged for one cycle on load_err.
module mod12_counter
  import mod12_counter_pkg::*;
#(
  parameter int MODULUS = DEF_MODULUS,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_r;
  logic             load_err_r;

  // Counter and reject flag; load beats increment, so a load on the terminal cycle does not wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r    <= RST_VAL;
      load_err_r <= 1'b0;
    end else if (load) begin
      if (din > MAX_VAL) begin
        count_r    <= RST_VAL;
        load_err_r <= 1'b1;
      end else begin
        count_r    <= din;
        load_err_r <= 1'b0;
      end
    end else begin
      if (count_r == MAX_VAL) begin
        count_r <= RST_VAL;
      end else begin
        count_r <= count_r + WIDTH'(1);
      end
      load_err_r <= 1'b0;
    end
  end

  assign count    = count_r;
  assign load_err = load_err_r;
  assign tc       = (count_r == MAX_VAL);

endmodule : mod12_counter

// File: tb/tb_mod12_counter.sv
// Scoreboard bench for mod12_counter: a reference model pushes expected state at
// each sampling edge, and the observed outputs are popped and compared just after it.
module tb_mod12_counter;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       load;
  logic [3:0] count;
  logic       tc;
  logic       load_err;

  typedef struct packed {
    logic [3:0] count;
    logic       tc;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_count;
  bit   m_err;

  mod12_counter dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .load     (load),
    .count    (count),
    .tc       (tc),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model of one clock edge with reset released.
  task automatic model_edge(input bit ld, input int d);
    if (ld) begin
      if (d >= 12) begin
        m_count = 0;
        m_err   = 1'b1;
      end else begin
        m_count = d;
        m_err   = 1'b0;
      end
    end else begin
      m_count = (m_count == 11) ? 0 : m_count + 1;
      m_err   = 1'b0;
    end
  endtask

  // Called at a negedge: drive, clock, push expectation, sample, compare; returns at next negedge.
  task automatic step(input string tag, input bit ld, input int d);
    exp_t e;
    exp_t got;
    load = ld;
    din  = 4'(d);
    @(posedge clk);
    model_edge(ld, d);
    e.count = 4'(m_count);
    e.tc    = (m_count == 11);
    e.err   = m_err;
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    check_val({tag, ".count"}, 8'(count), 8'(got.count));
    check_val({tag, ".tc"}, 8'(tc), 8'(got.tc));
    check_val({tag, ".load_err"}, 8'(load_err), 8'(got.err));
    @(negedge clk);
  endtask

  initial begin
    rst  = 1'b0;
    load = 1'b0;
    din  = 4'd0;
    m_count = 0;
    m_err   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst.count", 8'(count), 8'd0);
    check_val("rst.tc", 8'(tc), 8'd0);
    check_val("rst.load_err", 8'(load_err), 8'd0);

    // Free counting through two wraps
    rst = 1'b1;
    for (int i = 0; i < 30; i++) step("free", 1'b0, 0);

    // Load 11 then wrap on the first increment
    step("load11", 1'b1, 11);
    for (int i = 0; i < 3; i++) step("after11", 1'b0, 0);

    // Load 10 then 11, 0, 1
    step("load10", 1'b1, 10);
    for (int i = 0; i < 3; i++) step("after10", 1'b0, 0);

    // Out-of-range loads
    step("bad13", 1'b1, 13);
    step("bad13_next", 1'b0, 0);
    step("bad13_next2", 1'b0, 0);
    step("bad12", 1'b1, 12);
    step("bad15", 1'b1, 15);
    step("bad15_next", 1'b0, 0);

    // Async reset at count 7 with a load pending
    step("load7", 1'b1, 7);
    #2;
    rst  = 1'b0;
    load = 1'b1;
    din  = 4'd5;
    #1;
    check_val("async.count", 8'(count), 8'd0);
    check_val("async.tc", 8'(tc), 8'd0);
    @(posedge clk);
    #1;
    check_val("inrst.count", 8'(count), 8'd0);
    check_val("inrst.load_err", 8'(load_err), 8'd0);
    @(negedge clk);
    rst = 1'b1;
    m_count = 0;
    m_err   = 1'b0;
    step("post_rst", 1'b0, 0);

    // Async reset clears a pending load_err immediately
    step("bad14", 1'b1, 14);
    #2;
    rst = 1'b0;
    #1;
    check_val("async.load_err", 8'(load_err), 8'd0);
    @(negedge clk);
    rst = 1'b1;
    m_count = 0;
    m_err   = 1'b0;
    step("post_rst_load", 1'b1, 4);

    // Load in the terminal-count cycle takes priority over wrap
    step("prio_to11", 1'b1, 11);
    step("prio_load3", 1'b1, 3);
    step("prio_next", 1'b0, 0);

    // Mixed random traffic
    for (int i = 0; i < 40; i++) begin
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mod12_counter
